// File: rtl/lpddr3_pkg.sv
// rtl/lpddr3_pkg.sv - shared types, constants and helpers for the LPDDR3 request path
//
// Contents:
//   - default field widths and refresh timing
//   - request-code encodings (opaque to the scheduler, carried through)
//   - packed request entry struct {addr, req, busID, dataW, wen}
//   - refresh FSM state encoding
//   - adder_inc: pointer increment helper shared by the queue logic
package lpddr3_pkg;

  localparam int ADDR_W    = 37;
  localparam int BUSID_W   = 10;
  localparam int DATA_W    = 64;
  localparam int REQ_W     = 5;
  localparam int DEPTH_LOG = 3;

  localparam logic [15:0] REF_INTERVAL = 16'd3900;
  localparam logic [5:0]  REF_HOLD     = 6'd40;

  localparam logic [REQ_W-1:0] REQ_RD_LINE  = 5'd0;
  localparam logic [REQ_W-1:0] REQ_WR_LINE  = 5'd1;
  localparam logic [REQ_W-1:0] REQ_RD_WORD  = 5'd2;
  localparam logic [REQ_W-1:0] REQ_WR_WORD  = 5'd3;
  localparam logic [REQ_W-1:0] REQ_PREFETCH = 5'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [REQ_W-1:0]   req;
    logic [BUSID_W-1:0] busID;
    logic [DATA_W-1:0]  dataW;
    logic               wen;
  } req_entry_t;

  typedef enum logic [1:0] {
    REF_IDLE    = 2'd0,
    REF_PEND    = 2'd1,
    REF_HOLD_ST = 2'd2
  } ref_state_e;

  function automatic logic [15:0] adder_inc(input logic [15:0] v);
    return v + 16'd1;
  endfunction

endpackage

// File: rtl/lpddr3_req_fifo.sv
// rtl/lpddr3_req_fifo.sv - generic DEPTH x WIDTH FIFO with count/full/empty
//
// Ports:
//   clk, rst       core clock, synchronous active-high reset
//   push, wdata    write tail entry (caller only pushes when !full or popping)
//   pop            release head entry
//   rdata          current head entry (combinational from storage)
//   count          occupancy 0..DEPTH
//   full, empty    occupancy flags
module lpddr3_req_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic [DEPTH_LOG:0]   count,
  output logic                 full,
  output logic                 empty
);
  import lpddr3_pkg::*;

  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam int PTR_W = DEPTH_LOG + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Top bit of each pointer is a wrap flag that separates full from empty.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(adder_inc(16'(wr_ptr)));
      if (pop)  rd_ptr <= PTR_W'(adder_inc(16'(rd_ptr)));
    end
  end

  // A push while full is only legal alongside a pop; the head is read out
  // before this edge so overwriting its slot is safe.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[DEPTH_LOG-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]) &&
                 (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]);

endmodule

// File: rtl/lpddr3_req_sched.sv
// rtl/lpddr3_req_sched.sv - request scheduler and refresh timer in front of lpddr3_channel
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   in_en, in_addr, in_req,
//   in_busID, in_dataW, in_wen    request from the bus side
//   in_stall                      registered back-pressure to bus side
//   stall                         back-pressure from the channel
//   read_clkEn, read_addr,
//   read_req, read_busID,
//   read_dataW, read_wen          one issued request per cycle to the channel
//   ref_req                       one-cycle refresh command
//   ovf                           sticky overflow (request dropped while full)
module lpddr3_req_sched #(
  parameter int          ADDR_W       = lpddr3_pkg::ADDR_W,
  parameter int          BUSID_W      = lpddr3_pkg::BUSID_W,
  parameter int          DATA_W       = lpddr3_pkg::DATA_W,
  parameter int          REQ_W        = lpddr3_pkg::REQ_W,
  parameter int          DEPTH_LOG    = lpddr3_pkg::DEPTH_LOG,
  parameter logic [15:0] REF_INTERVAL = lpddr3_pkg::REF_INTERVAL,
  parameter logic [5:0]  REF_HOLD     = lpddr3_pkg::REF_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_en,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [REQ_W-1:0]   in_req,
  input  logic [BUSID_W-1:0] in_busID,
  input  logic [DATA_W-1:0]  in_dataW,
  input  logic               in_wen,
  output logic               in_stall,
  input  logic               stall,
  output logic               read_clkEn,
  output logic [ADDR_W-1:0]  read_addr,
  output logic [REQ_W-1:0]   read_req,
  output logic [BUSID_W-1:0] read_busID,
  output logic [DATA_W-1:0]  read_dataW,
  output logic               read_wen,
  output logic               ref_req,
  output logic               ovf
);
  import lpddr3_pkg::*;

  localparam int ENT_W = ADDR_W + REQ_W + BUSID_W + DATA_W + 1;
  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam int CNT_W = DEPTH_LOG + 1;

  logic [ENT_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;
  logic             issue;
  logic             push;

  ref_state_e  ref_state;
  logic [15:0] ref_cnt;
  logic [5:0]  hold_cnt;
  logic        ref_pending;
  logic        ref_fire;
  logic        ref_go;

  // Counter reaching zero this cycle; it also blocks issue in the same cycle
  // so refresh always wins against a coincident request.
  assign ref_fire = (ref_cnt == 16'd1);

  assign issue = !empty && !stall && !ref_pending && !ref_fire &&
                 (ref_state == REF_IDLE) && (hold_cnt == '0);
  assign push  = in_en && (!full || issue);
  assign ref_go = (ref_state == REF_PEND) && !stall && !issue;
  assign count_next = count + CNT_W'(push) - CNT_W'(issue);

  lpddr3_req_fifo #(
    .WIDTH     (ENT_W),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue),
    .wdata ({in_addr, in_req, in_busID, in_dataW, in_wen}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      read_clkEn <= 1'b0;
      read_addr  <= '0;
      read_req   <= '0;
      read_busID <= '0;
      read_dataW <= '0;
      read_wen   <= 1'b0;
      in_stall   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      read_clkEn <= issue;
      if (issue) {read_addr, read_req, read_busID, read_dataW, read_wen} <= head;
      // Two slots of skid for a bus side that sees in_stall one cycle late.
      in_stall <= (count_next >= CNT_W'(DEPTH - 2));
      if (in_en && full && !issue) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_state   <= REF_IDLE;
      ref_cnt     <= REF_INTERVAL;
      hold_cnt    <= '0;
      ref_pending <= 1'b0;
      ref_req     <= 1'b0;
    end else begin
      ref_req <= 1'b0;
      ref_cnt <= ref_fire ? REF_INTERVAL : ref_cnt - 16'd1;
      // An expiry while already pending is absorbed; a fresh expiry in the
      // cycle the pending one is serviced starts a new pending refresh.
      ref_pending <= ref_fire || (ref_pending && !ref_go);
      case (ref_state)
        REF_IDLE: begin
          if (ref_pending) ref_state <= REF_PEND;
        end
        REF_PEND: begin
          if (ref_go) begin
            ref_req   <= 1'b1;
            hold_cnt  <= REF_HOLD;
            ref_state <= REF_HOLD_ST;
          end
        end
        REF_HOLD_ST: begin
          if (hold_cnt == '0) ref_state <= REF_IDLE;
          else                hold_cnt  <= hold_cnt - 6'd1;
        end
        default: ref_state <= REF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr3_req_sched.sv
// tb/tb_lpddr3_req_sched.sv - self-checking bench for lpddr3_req_sched
module tb_lpddr3_req_sched;

  localparam int RI = 20;
  localparam int RH = 4;
  localparam int EW = 37 + 5 + 10 + 64 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en;
  logic [36:0] in_addr;
  logic [4:0]  in_req;
  logic [9:0]  in_busID;
  logic [63:0] in_dataW;
  logic        in_wen;
  logic        in_stall;
  logic        stall;
  logic        read_clkEn;
  logic [36:0] read_addr;
  logic [4:0]  read_req;
  logic [9:0]  read_busID;
  logic [63:0] read_dataW;
  logic        read_wen;
  logic        ref_req;
  logic        ovf;

  lpddr3_req_sched #(
    .ADDR_W(37), .BUSID_W(10), .DATA_W(64), .REQ_W(5), .DEPTH_LOG(3),
    .REF_INTERVAL(16'd20), .REF_HOLD(6'd4)
  ) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_addr(in_addr), .in_req(in_req),
    .in_busID(in_busID), .in_dataW(in_dataW), .in_wen(in_wen), .in_stall(in_stall),
    .stall(stall), .read_clkEn(read_clkEn), .read_addr(read_addr), .read_req(read_req),
    .read_busID(read_busID), .read_dataW(read_dataW), .read_wen(read_wen),
    .ref_req(ref_req), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of requests plus a refresh timeline kept as
  // edge numbers counted from the end of reset.
  logic [EW-1:0] q[$];
  int  e;
  int  last_ref;
  bit  pending;
  bit  armed;
  bit  started = 0;
  bit  m_clken, m_ref, m_install, m_ovf;
  logic [EW-1:0] m_fields;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      e = 0; last_ref = -1000; pending = 0; armed = 0; q.delete();
      m_clken = 0; m_ref = 0; m_install = 0; m_ovf = 0; m_fields = '0;
    end else begin
      bit hold_done, fire, do_issue, do_ref;
      int pre_size;
      e++;
      hold_done = (e >= last_ref + RH + 2);
      fire      = (e % RI == 0);
      pre_size  = q.size();
      do_issue  = pre_size > 0 && !stall && !pending && !fire && hold_done && !armed;
      do_ref    = armed && !stall;
      if (do_ref) begin
        armed = 0;
        last_ref = e;
      end else if (hold_done && !armed && pending) begin
        armed = 1;
      end
      pending = fire || (pending && !do_ref);
      m_ref   = do_ref;
      m_clken = do_issue;
      if (do_issue) m_fields = q.pop_front();
      if (in_en && (pre_size < 8 || do_issue))
        q.push_back({in_addr, in_req, in_busID, in_dataW, in_wen});
      if (in_en && pre_size == 8 && !do_issue) m_ovf = 1;
      m_install = (q.size() >= 6);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("read_clkEn", read_clkEn, m_clken);
      chk("read_fields", {read_addr, read_req, read_busID, read_dataW, read_wen}, m_fields);
      chk("ref_req", ref_req, m_ref);
      chk("in_stall", in_stall, m_install);
      chk("ovf", ovf, m_ovf);
      chk("clkEn_ref_excl", read_clkEn & ref_req, 0);
    end
  end

  task automatic rand_fields();
    in_addr  = 37'({$urandom(), $urandom()});
    in_req   = 5'($urandom_range(0, 31));
    in_busID = 10'($urandom_range(0, 1023));
    in_dataW = {$urandom(), $urandom()};
    in_wen   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int stall_left;
    rst = 1; in_en = 0; stall = 0;
    in_addr = '0; in_req = '0; in_busID = '0; in_dataW = '0; in_wen = 0;
    repeat (3) @(negedge clk);
    chk("rst_clkEn", read_clkEn, 0);
    chk("rst_ref", ref_req, 0);
    chk("rst_install", in_stall, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_addr", read_addr, 0);
    rst = 0;

    // single read, two-cycle latency, one-cycle pulse
    in_en = 1; in_addr = 37'h1000; in_busID = 10'd5; in_wen = 0;
    @(negedge clk); in_en = 0;
    chk("single_early", read_clkEn, 0);
    @(negedge clk);
    chk("single_clkEn", read_clkEn, 1);
    chk("single_addr", read_addr, 37'h1000);
    chk("single_busID", read_busID, 10'd5);
    chk("single_wen", read_wen, 0);
    @(negedge clk);
    chk("single_once", read_clkEn, 0);

    // burst under channel stall, then overflow
    stall = 1;
    for (int k = 1; k <= 8; k++) begin
      rand_fields(); in_en = 1;
      @(negedge clk);
      chk("burst_install", in_stall, (k >= 6) ? 1 : 0);
    end
    chk("burst_no_ovf", ovf, 0);
    rand_fields(); in_en = 1;
    @(negedge clk); in_en = 0;
    chk("ovf_set", ovf, 1);
    stall = 0;
    repeat (30) @(negedge clk);
    chk("ovf_sticky", ovf, 1);
    chk("drained_install", in_stall, 0);

    // reset mid-burst
    stall = 1;
    for (int k = 0; k < 5; k++) begin
      rand_fields(); in_en = 1; @(negedge clk);
    end
    in_en = 0; rst = 1;
    @(negedge clk);
    chk("midrst_clkEn", read_clkEn, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_install", in_stall, 0);
    rst = 0; stall = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("midrst_no_issue", read_clkEn, 0);
    end

    // refresh held off by stall; fires on edge 20, emitted once stall drops
    rst = 1; @(negedge clk);
    rst = 0; stall = 1;
    for (int k = 0; k < 3; k++) begin
      rand_fields(); in_en = 1; @(negedge clk);
    end
    in_en = 0;
    repeat (27) @(negedge clk);
    chk("ref_blocked", ref_req, 0);
    stall = 0;
    @(negedge clk);
    chk("ref_after_stall", ref_req, 1);
    chk("ref_no_clkEn", read_clkEn, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ref_hold_block", read_clkEn, 0);
    end
    @(negedge clk);
    chk("ref_resume", read_clkEn, 1);

    // randomized traffic against the model
    stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        stall = 1; stall_left--;
      end else begin
        stall = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 60) == 0) stall_left = $urandom_range(5, 30);
      end
      rand_fields();
      in_en = ($urandom_range(0, 9) < 7) && (!in_stall || $urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 500) == 0);
    end
    @(negedge clk); rst = 0; in_en = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
